// File: rtl/tmds_pkg.sv
// Shared constants and types for the TMDS channel encoder.
package tmds_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned QM_W   = DATA_W + 1;
    localparam int unsigned SYM_W  = 10;
    localparam int unsigned CTRL_W = 2;

    localparam logic [SYM_W-1:0] CTRL_SYM_00 = 10'h354;
    localparam logic [SYM_W-1:0] CTRL_SYM_01 = 10'h0AB;
    localparam logic [SYM_W-1:0] CTRL_SYM_10 = 10'h154;
    localparam logic [SYM_W-1:0] CTRL_SYM_11 = 10'h2AB;

    // Running disparity and its widened form for intermediate sums.
    typedef logic signed [4:0] disp_t;
    typedef logic signed [5:0] disp_ext_t;

    // Population count of a data byte.
    function automatic logic [3:0] count_ones(input logic [DATA_W-1:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < int'(DATA_W); i++) begin
            n = n + 4'(v[i]);
        end
        return n;
    endfunction

    // Control period symbol lookup for {C1,C0}.
    function automatic logic [SYM_W-1:0] ctrl_symbol(input logic [CTRL_W-1:0] c);
        logic [SYM_W-1:0] s;
        case (c)
            2'b00:   s = CTRL_SYM_00;
            2'b01:   s = CTRL_SYM_01;
            2'b10:   s = CTRL_SYM_10;
            default: s = CTRL_SYM_11;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/tmds_encoder_if.sv
// Pixel-side word stream into the encoder and symbol stream out of it.
interface tmds_encoder_if;
    import tmds_pkg::*;

    logic                valid;
    logic                de;
    logic [DATA_W-1:0]   data;
    logic [CTRL_W-1:0]   ctrl;
    logic                tmds_valid;
    logic [SYM_W-1:0]    tmds;

    modport master (
        output valid, de, data, ctrl,
        input  tmds_valid, tmds
    );

    modport slave (
        input  valid, de, data, ctrl,
        output tmds_valid, tmds
    );

endinterface

// File: rtl/tmds_encoder_tm_choice.sv
// Transition-minimisation: XOR or XNOR chain chosen by the byte's ones count.
module TM_Choice
    import tmds_pkg::*;
(
    input  logic [DATA_W-1:0] i_data,
    output logic [QM_W-1:0]   o_qm_c
);

    logic [3:0]        n1;
    logic              use_xnor;
    logic [QM_W-1:0]   qm;

    // Build the chained word; qm[8]=1 marks the XOR form.
    always_comb begin
        n1       = count_ones(i_data);
        use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !i_data[0]);
        qm       = '0;
        qm[0]    = i_data[0];
        for (int i = 1; i < int'(DATA_W); i++) begin
            qm[i] = use_xnor ? ~(qm[i-1] ^ i_data[i]) : (qm[i-1] ^ i_data[i]);
        end
        qm[DATA_W] = ~use_xnor;
    end

    assign o_qm_c = qm;

endmodule

// File: rtl/tmds_encoder.sv
// Two-stage TMDS channel encoder: transition minimisation, then DC balancing.
module tmds_encoder
    import tmds_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_valid,
    input  logic               i_de,
    input  logic [DATA_W-1:0]  i_data,
    input  logic [CTRL_W-1:0]  i_ctrl,
    output logic               o_valid,
    output logic [SYM_W-1:0]   o_tmds
);

    logic [QM_W-1:0]   qm_c;

    logic              s1_valid_q, s1_valid_d;
    logic              s1_de_q,    s1_de_d;
    logic [CTRL_W-1:0] s1_ctrl_q,  s1_ctrl_d;
    logic [QM_W-1:0]   s1_qm_q,    s1_qm_d;

    logic              valid_q, valid_d;
    logic [SYM_W-1:0]  tmds_q,  tmds_d;
    disp_t             cnt_q,   cnt_d;

    logic [3:0]        n1;
    disp_ext_t         diff;
    disp_ext_t         cnt_x;
    disp_ext_t         sum;
    logic              qm8;
    logic [DATA_W-1:0] qm_lo;

    TM_Choice u_tm_choice (
        .i_data (i_data),
        .o_qm_c (qm_c)
    );

    // Stage 1 capture: every cycle, bubbles included.
    always_comb begin
        s1_valid_d = i_valid;
        s1_de_d    = i_de;
        s1_ctrl_d  = i_ctrl;
        s1_qm_d    = qm_c;
    end

    // Stage 1 registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_valid_q <= 1'b0;
            s1_de_q    <= 1'b0;
            s1_ctrl_q  <= '0;
            s1_qm_q    <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_de_q    <= s1_de_d;
            s1_ctrl_q  <= s1_ctrl_d;
            s1_qm_q    <= s1_qm_d;
        end
    end

    // Stage 2 DC balance; bubbles hold symbol and disparity.
    always_comb begin
        valid_d = s1_valid_q;
        tmds_d  = tmds_q;
        cnt_d   = cnt_q;
        qm8     = s1_qm_q[DATA_W];
        qm_lo   = s1_qm_q[DATA_W-1:0];
        n1      = count_ones(qm_lo);
        diff    = $signed(6'({n1, 1'b0})) - 6'sd8;  // N1 - N0
        cnt_x   = disp_ext_t'(cnt_q);
        sum     = cnt_x;
        if (s1_valid_q) begin
            if (!s1_de_q) begin
                tmds_d = ctrl_symbol(s1_ctrl_q);
                cnt_d  = '0;
            end else begin
                if ((cnt_q == 5'sd0) || (diff == 6'sd0)) begin
                    tmds_d = {~qm8, qm8, (qm8 ? qm_lo : ~qm_lo)};
                    sum    = qm8 ? (cnt_x + diff) : (cnt_x - diff);
                end else if (((cnt_q > 5'sd0) && (diff > 6'sd0)) ||
                             ((cnt_q < 5'sd0) && (diff < 6'sd0))) begin
                    tmds_d = {1'b1, qm8, ~qm_lo};
                    sum    = cnt_x + (qm8 ? 6'sd2 : 6'sd0) - diff;
                end else begin
                    tmds_d = {1'b0, qm8, qm_lo};
                    sum    = cnt_x + diff - (qm8 ? 6'sd0 : 6'sd2);
                end
                cnt_d = disp_t'(sum);
            end
        end
    end

    // Stage 2 registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q <= 1'b0;
            tmds_q  <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            tmds_q  <= tmds_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_valid = valid_q;
    assign o_tmds  = tmds_q;

endmodule

// File: tb/tb_tmds_encoder.sv
// Bench for tmds_encoder: directed vectors plus a randomized stream against a reference model.
module tb_tmds_encoder;

    typedef struct {
        bit       v;
        bit       de;
        bit [7:0] data;
        bit [9:0] t;
        int       c;
    } exp_t;

    logic clk;
    logic rst_n;

    tmds_encoder_if bus ();

    tmds_encoder dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_valid (bus.valid),
        .i_de    (bus.de),
        .i_data  (bus.data),
        .i_ctrl  (bus.ctrl),
        .o_valid (bus.tmds_valid),
        .o_tmds  (bus.tmds)
    );

    int total = 0;
    int bad   = 0;

    bit [9:0] ctrl_tab [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};

    exp_t     exp_q[$];
    exp_t     exp_e;
    int       m_cnt;
    bit [9:0] m_tmds;

    bit       obs_valid;
    bit [9:0] obs_tmds;
    int       obs_cnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference encoder: computes the symbol for one word straight from the encoding rules.
    function automatic void model_push(bit v, bit de, bit [7:0] d, bit [1:0] c);
        exp_t     e;
        int       n1d, n1, n0;
        bit       use_xnor;
        bit [8:0] qm;
        e.v = v; e.de = de; e.data = d;
        if (v && !de) begin
            m_tmds = ctrl_tab[c];
            m_cnt  = 0;
        end else if (v) begin
            n1d      = $countones(d);
            use_xnor = (n1d > 4) || (n1d == 4 && d[0] == 1'b0);
            qm[0]    = d[0];
            for (int i = 1; i < 8; i++)
                qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
            qm[8] = ~use_xnor;
            n1 = $countones(qm[7:0]);
            n0 = 8 - n1;
            if (m_cnt == 0 || n1 == n0) begin
                m_tmds = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
                m_cnt  = m_cnt + (qm[8] ? (n1 - n0) : (n0 - n1));
            end else if ((m_cnt > 0 && n1 > n0) || (m_cnt < 0 && n0 > n1)) begin
                m_tmds = {1'b1, qm[8], ~qm[7:0]};
                m_cnt  = m_cnt + 2 * int'(qm[8]) + (n0 - n1);
            end else begin
                m_tmds = {1'b0, qm[8], qm[7:0]};
                m_cnt  = m_cnt + (n1 - n0) - 2 * (qm[8] ? 0 : 1);
            end
        end
        e.t = m_tmds;
        e.c = m_cnt;
        exp_q.push_back(e);
    endfunction

    // Model state after reset: two empty pipeline slots holding the reset outputs.
    function automatic void model_clear();
        exp_t e;
        m_cnt  = 0;
        m_tmds = '0;
        exp_q.delete();
        e.v = 1'b0; e.de = 1'b0; e.data = '0; e.t = '0; e.c = 0;
        exp_q.push_back(e);
        exp_q.push_back(e);
    endfunction

    // One cycle: sample outputs at the falling edge, then present the next word.
    task automatic drive(input bit v, input bit de, input bit [7:0] d, input bit [1:0] c);
        @(negedge clk);
        obs_valid = bus.tmds_valid;
        obs_tmds  = bus.tmds;
        obs_cnt   = dut.cnt_q;
        if (exp_q.size() > 0) exp_e = exp_q.pop_front();
        else begin exp_e.v = 1'b0; exp_e.de = 1'b0; exp_e.data = '0; exp_e.t = '0; exp_e.c = 0; end
        bus.valid = v;
        bus.de    = de;
        bus.data  = d;
        bus.ctrl  = c;
        model_push(v, de, d, c);
    endtask

    task automatic do_reset();
        bus.valid = 1'b0; bus.de = 1'b0; bus.data = '0; bus.ctrl = '0;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
    endtask

    task automatic test_reset();
        bus.valid = 1'b1; bus.de = 1'b1; bus.data = 8'hA5; bus.ctrl = 2'b11;
        rst_n = 1'b0;
        #12;
        total++; if (bus.tmds_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", bus.tmds_valid); end
        total++; if (bus.tmds !== 10'h000) begin bad++; $display("FAIL reset_tmds got=%h want=000", bus.tmds); end
        total++; if (dut.cnt_q !== 5'sd0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", dut.cnt_q); end
        total++; if (dut.s1_valid_q !== 1'b0 || dut.s1_qm_q !== 9'h0) begin bad++; $display("FAIL reset_stage1 got=%b/%h want=0/000", dut.s1_valid_q, dut.s1_qm_q); end
        do_reset();
    endtask

    task automatic test_ctrl();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(i < 4, 1'b0, 8'h00, 2'(i));
            if (i >= 2) begin
                total++; if (obs_valid !== 1'b1 || obs_tmds !== ctrl_tab[i-2] || obs_cnt != 0) begin
                    bad++; $display("FAIL ctrl%0d got=%b/%h/%0d want=1/%h/0", i-2, obs_valid, obs_tmds, obs_cnt, ctrl_tab[i-2]);
                end
            end
        end
    endtask

    task automatic test_zeros();
        bit [9:0] want_t [3] = '{10'h100, 10'h3FF, 10'h100};
        int       want_c [3] = '{-8, 2, -6};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(i < 3, 1'b1, 8'h00, 2'b00);
            if (i >= 2) begin
                total++; if (obs_valid !== 1'b1 || obs_tmds !== want_t[i-2] || obs_cnt != want_c[i-2]) begin
                    bad++; $display("FAIL zeros%0d got=%b/%h/%0d want=1/%h/%0d", i-2, obs_valid, obs_tmds, obs_cnt, want_t[i-2], want_c[i-2]);
                end
            end
        end
    endtask

    task automatic test_ff();
        do_reset();
        drive(1'b1, 1'b1, 8'hFF, 2'b00);
        drive(1'b0, 1'b0, 8'h00, 2'b00);
        drive(1'b0, 1'b0, 8'h00, 2'b00);
        total++; if (obs_valid !== 1'b1 || obs_tmds !== 10'h200 || obs_cnt != -8) begin
            bad++; $display("FAIL ff got=%b/%h/%0d want=1/200/-8", obs_valid, obs_tmds, obs_cnt);
        end
    endtask

    task automatic test_bubble();
        bit       want_v [3] = '{1'b1, 1'b0, 1'b1};
        bit [9:0] want_t [3] = '{10'h100, 10'h100, 10'h3FF};
        int       want_c [3] = '{-8, -8, 2};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(i == 0 || i == 2, 1'b1, 8'h00, 2'b00);
            if (i >= 2) begin
                total++; if (obs_valid !== want_v[i-2] || obs_tmds !== want_t[i-2] || obs_cnt != want_c[i-2]) begin
                    bad++; $display("FAIL bubble%0d got=%b/%h/%0d want=%b/%h/%0d", i-2, obs_valid, obs_tmds, obs_cnt, want_v[i-2], want_t[i-2], want_c[i-2]);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 8'(8'h3C + i), 2'b00);
        #2;
        total++; if (bus.tmds_valid !== 1'b1) begin bad++; $display("FAIL arst_full got=%b want=1", bus.tmds_valid); end
        rst_n = 1'b0;
        #1;
        total++; if (bus.tmds_valid !== 1'b0 || bus.tmds !== 10'h000) begin
            bad++; $display("FAIL arst_clear got=%b/%h want=0/000", bus.tmds_valid, bus.tmds);
        end
        do_reset();
        drive(1'b1, 1'b1, 8'h00, 2'b00);
        drive(1'b0, 1'b0, 8'h00, 2'b00);
        total++; if (obs_valid !== 1'b0) begin bad++; $display("FAIL arst_drop got=%b want=0", obs_valid); end
        drive(1'b0, 1'b0, 8'h00, 2'b00);
        total++; if (obs_valid !== 1'b1 || obs_tmds !== 10'h100 || obs_cnt != -8) begin
            bad++; $display("FAIL arst_first got=%b/%h/%0d want=1/100/-8", obs_valid, obs_tmds, obs_cnt);
        end
    endtask

    task automatic test_random();
        bit       de  = 1'b1;
        int       run = 10;
        bit [7:0] dd, dec;
        do_reset();
        for (int i = 0; i < 602; i++) begin
            if (run == 0) begin
                de  = ~de;
                run = de ? int'($urandom_range(30, 1)) : int'($urandom_range(6, 1));
            end
            run--;
            if (i < 600) drive(($urandom % 4) != 0, de, 8'($urandom), 2'($urandom));
            else         drive(1'b0, 1'b0, 8'h00, 2'b00);
            total++; if (obs_valid !== exp_e.v || obs_tmds !== exp_e.t || obs_cnt != exp_e.c) begin
                bad++; $display("FAIL rand%0d got=%b/%h/%0d want=%b/%h/%0d", i, obs_valid, obs_tmds, obs_cnt, exp_e.v, exp_e.t, exp_e.c);
            end
            if (exp_e.v && exp_e.de) begin
                dd     = obs_tmds[9] ? ~obs_tmds[7:0] : obs_tmds[7:0];
                dec[0] = dd[0];
                for (int k = 1; k < 8; k++)
                    dec[k] = obs_tmds[8] ? (dd[k] ^ dd[k-1]) : ~(dd[k] ^ dd[k-1]);
                total++; if (dec !== exp_e.data) begin
                    bad++; $display("FAIL decode%0d got=%h want=%h", i, dec, exp_e.data);
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        bus.valid = 1'b0; bus.de = 1'b0; bus.data = '0; bus.ctrl = '0;
        test_reset();
        test_ctrl();
        test_zeros();
        test_ff();
        test_bubble();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tmds_encoder.md
TMDS_ENCODER -- requirements
Module: tmds_encoder

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; the ports are named i_clk and i_rst_n.
REQ-002 Port i_clk, input, 1 bit: pixel clock; all state SHALL update on its rising edge.
REQ-003 Port i_rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 Port i_valid, input, 1 bit: the input word is present this cycle.
REQ-005 Port i_de, input, 1 bit: data enable; 1 means video data, 0 means a control period.
REQ-006 Port i_data, input, 8 bits: pixel byte, sampled when i_valid=1 and i_de=1.
REQ-007 Port i_ctrl, input, 2 bits: control bits {C1,C0}, sampled when i_valid=1 and i_de=0.
REQ-008 Port o_valid, output, 1 bit: o_tmds holds a new symbol this cycle.
REQ-009 Port o_tmds, output, 10 bits: TMDS symbol; bit 0 is serialized first.

Function
REQ-010 Stage 1 SHALL pass i_data through the transition-minimization function and register qm[8:0], i_de, i_ctrl and i_valid.
REQ-011 Stage 2 SHALL perform DC balancing and register o_tmds, o_valid and the running disparity cnt.
REQ-012 Latency SHALL be exactly 2 cycles: o_valid equals i_valid delayed by 2 cycles, with no stalls and no back-pressure.
REQ-013 cnt SHALL be a signed 5-bit value; intermediate sums SHALL be computed in at least 6 signed bits.
REQ-014 N1 = number of ones in qm[7:0]; N0 = 8 - N1.
REQ-015 Case A, cnt==0 or N1==N0:
  - o_tmds = {~qm8, qm8, qm8 ? qm[7:0] : ~qm[7:0]};
  - cnt += (qm8 ? N1-N0 : N0-N1).
REQ-016 Case B, (cnt>0 and N1>N0) or (cnt<0 and N0>N1):
  - o_tmds = {1, qm8, ~qm[7:0]};
  - cnt += 2*qm8 + (N0-N1).
REQ-017 Case C, otherwise:
  - o_tmds = {0, qm8, qm[7:0]};
  - cnt += (N1-N0) - 2*(~qm8).
REQ-018 A control word (de=0) SHALL map i_ctrl to o_tmds as: 00 -> 10'h354, 01 -> 10'h0AB, 10 -> 10'h154, 11 -> 10'h2AB.
REQ-019 A control word SHALL force cnt to 0.
REQ-020 A stage holding a word with valid=0 SHALL leave cnt and o_tmds unchanged; o_valid SHALL be 0 that cycle.
REQ-021 A de 1->0->1 transition SHALL take effect on the exact symbol it accompanies; symbols SHALL NOT be merged or dropped.

Reset
REQ-022 While i_rst_n=0, the block SHALL hold o_valid=0, o_tmds=10'h000, cnt=0, and all stage-1 registers at 0, regardless of i_clk.
REQ-023 Reset asserted mid-stream SHALL discard all in-flight words.
REQ-024 After reset release, the first valid input SHALL appear on the output 2 cycles later, encoded from cnt=0.

Structure
REQ-025 Package tmds_pkg SHALL hold:
  - the four control-symbol constants;
  - the disparity typedef (signed 5-bit);
  - the symbol width constant (10).
REQ-026 The transition-minimization stage SHALL be the existing TM_Choice module, instantiated once as the only sub-module.
REQ-027 DC balancing SHALL be inline combinational logic feeding the stage-2 registers.

Verification
REQ-028 Reset, then i_valid=1, i_de=0, i_ctrl=00 -> after 2 cycles, o_valid=1, o_tmds=10'h354, cnt=0; repeat for ctrl 01, 10 and 11 -> 0AB, 154, 2AB.
REQ-029 From cnt=0, i_data=0x00 for three consecutive cycles -> o_tmds = 10'h100, 10'h3FF, 10'h100; cnt = -8, +2, -6.
REQ-030 From cnt=0, i_data=0xFF -> o_tmds = 10'h200, cnt = -8.
REQ-031 Send 0x00, then one bubble (i_valid=0), then 0x00 -> outputs 10'h100, a bubble, 10'h3FF; cnt holds at -8 through the bubble.
REQ-032 Assert i_rst_n=0 asynchronously between clock edges while the pipeline is full -> o_valid and o_tmds clear immediately; the first post-reset 0x00 yields 10'h100.
REQ-033 Random data with random control periods, checked against a reference model -> every symbol matches; cnt stays within the signed 5-bit range; every 10-bit data symbol decodes back to its input byte.
